// File: rtl/aes_prng_masking_mc.sv
// Masking PRNG for the AES cipher core: per-chunk Galois LFSRs feeding PRINCE
// S-boxes, N-way chunk rotation, and an entropy collector that reseeds all
// chunks on external request or after a programmable number of updates.

// One chunk: Galois XOR LFSR, output bit permutation, nibble-wise PRINCE S-box.
module aes_prng_masking_mc_chunk #(
  parameter int unsigned                          ChunkSize   = 32,
  parameter logic [ChunkSize-1:0]                 DefaultSeed = '0,
  parameter logic [ChunkSize*$clog2(ChunkSize)-1:0] Perm      = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 lfsr_en_i,
  input  logic                 seed_en_i,
  input  logic [ChunkSize-1:0] seed_i,
  output logic [ChunkSize-1:0] sub_o
);
  localparam int unsigned IdxW = $clog2(ChunkSize);
  // Maximal-length 32-bit Galois polynomial; PRINCE 4-bit S-box, entry n at [4n+:4].
  localparam logic [ChunkSize-1:0] Coeffs = ChunkSize'(32'h8000_0057);
  localparam logic [63:0]          SBox   = 64'h4D5E_0876_19CA_23FB;

  logic [ChunkSize-1:0] lfsr_q, perm_st;

  // LFSR state; a reseed wins over a step in the same cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)        lfsr_q <= DefaultSeed;
    else if (seed_en_i) lfsr_q <= seed_i;
    else if (lfsr_en_i) lfsr_q <= (lfsr_q >> 1) ^ ({ChunkSize{lfsr_q[0]}} & Coeffs);
  end

  // Output bit k is taken from state bit Perm[k].
  always_comb begin
    perm_st = '0;
    for (int k = 0; k < ChunkSize; k++) perm_st[k] = lfsr_q[Perm[k*IdxW +: IdxW]];
  end

  // Per-nibble S-box substitution (two nibbles make the 8-bit S-box).
  always_comb begin
    sub_o = '0;
    for (int n = 0; n < ChunkSize/4; n++) sub_o[4*n +: 4] = SBox[{perm_st[4*n +: 4], 2'b00} +: 4];
  end
endmodule

module aes_prng_masking_mc #(
  parameter int unsigned Width                = 160,
  parameter int unsigned ChunkSize            = 32,
  parameter int unsigned EntropyWidth         = 32,
  parameter int unsigned CntW                 = 16,
  parameter bit          SecAllowForcingMasks = 1'b0,
  parameter bit          SecSkipPRNGReseeding = 1'b0,
  parameter logic [Width-1:0] RndCnstLfsrSeed =
    160'hc32d_580f_74f1_713a_b0f7_b1e1_8a9d_6e2c_4f3b_7d19,
  // Default entry k = (7k+3) mod 32, listed from k=31 down to k=0.
  parameter logic [ChunkSize*$clog2(ChunkSize)-1:0] RndCnstChunkLfsrPerm = {
    5'd28, 5'd21, 5'd14, 5'd7,  5'd0,  5'd25, 5'd18, 5'd11,
    5'd4,  5'd29, 5'd22, 5'd15, 5'd8,  5'd1,  5'd26, 5'd19,
    5'd12, 5'd5,  5'd30, 5'd23, 5'd16, 5'd9,  5'd2,  5'd27,
    5'd20, 5'd13, 5'd6,  5'd31, 5'd24, 5'd17, 5'd10, 5'd3}
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    force_zero_masks_i,
  input  logic                    data_update_i,
  output logic [Width-1:0]        data_o,
  input  logic                    reseed_req_i,
  output logic                    reseed_ack_o,
  input  logic [CntW-1:0]         reseed_interval_i,
  output logic                    reseed_busy_o,
  output logic                    entropy_req_o,
  input  logic                    entropy_ack_i,
  input  logic [EntropyWidth-1:0] entropy_i
);
  localparam int unsigned NumChunks = Width / ChunkSize;
  localparam int unsigned NumWords  = Width / EntropyWidth;
  localparam int unsigned PhW       = $clog2(NumChunks);
  localparam int unsigned WcntW     = (NumWords > 1) ? $clog2(NumWords) : 1;

  typedef enum logic [1:0] {StIdle, StCollect, StApply} state_e;

  state_e                                  state_q, state_d;
  logic                                    ext_pend_q, ext_pend_d;
  logic                                    wr_word, apply, trigger, auto_due;
  logic [WcntW-1:0]                        wcnt_q;
  logic [PhW-1:0]                          phase_q;
  logic [CntW-1:0]                         upd_cnt_q;
  logic [NumWords-1:0][EntropyWidth-1:0]   seed_q;
  logic [Width-1:0]                        seed_flat;
  logic [NumChunks-1:0][ChunkSize-1:0]     sub, rot;

  assign seed_flat = seed_q;
  assign auto_due  = (reseed_interval_i != '0) && (upd_cnt_q >= reseed_interval_i);
  assign trigger   = !SecSkipPRNGReseeding && (reseed_req_i || auto_due);

  for (genvar c = 0; c < NumChunks; c++) begin : g_chunk
    aes_prng_masking_mc_chunk #(
      .ChunkSize  (ChunkSize),
      .DefaultSeed(RndCnstLfsrSeed[c*ChunkSize +: ChunkSize]),
      .Perm       (RndCnstChunkLfsrPerm)
    ) u_chunk (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .lfsr_en_i(data_update_i),
      .seed_en_i(apply),
      .seed_i   (seed_flat[c*ChunkSize +: ChunkSize]),
      .sub_o    (sub[c])
    );
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Next state, collector strobes and handshake outputs.
  always_comb begin
    state_d       = state_q;
    ext_pend_d    = ext_pend_q;
    wr_word       = 1'b0;
    apply         = 1'b0;
    entropy_req_o = 1'b0;
    reseed_busy_o = (state_q != StIdle);
    case (state_q)
      StIdle: begin
        if (trigger) begin
          state_d    = StCollect;
          ext_pend_d = reseed_req_i;
        end
      end
      StCollect: begin
        entropy_req_o = 1'b1;
        if (reseed_req_i) ext_pend_d = 1'b1;
        if (entropy_ack_i) begin
          wr_word = 1'b1;
          if (wcnt_q == WcntW'(NumWords-1)) state_d = StApply;
        end
      end
      StApply: begin
        apply      = 1'b1;
        ext_pend_d = 1'b0;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
    reseed_ack_o = SecSkipPRNGReseeding ? reseed_req_i : (apply & ext_pend_q);
  end

  // Seed assembly, phase and update counter; an APPLY-cycle update still counts.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ext_pend_q <= 1'b0;
      wcnt_q     <= '0;
      seed_q     <= '0;
      phase_q    <= '0;
      upd_cnt_q  <= '0;
    end else begin
      ext_pend_q <= ext_pend_d;
      if (wr_word) begin
        seed_q[wcnt_q] <= entropy_i;
        wcnt_q         <= wcnt_q + 1'b1;
      end
      if (apply) wcnt_q <= '0;
      if (data_update_i)
        phase_q <= (phase_q == PhW'(NumChunks-1)) ? '0 : phase_q + 1'b1;
      if (apply)                                     upd_cnt_q <= '0;
      else if (data_update_i && (upd_cnt_q != '1))   upd_cnt_q <= upd_cnt_q + 1'b1;
    end
  end

  // Output chunk i is S-box chunk (i + phase) mod NumChunks.
  always_comb begin
    rot = '0;
    for (int i = 0; i < NumChunks; i++) begin
      if (i + int'(phase_q) >= NumChunks) rot[i] = sub[i + int'(phase_q) - NumChunks];
      else                                rot[i] = sub[i + int'(phase_q)];
    end
  end

  assign data_o = (SecAllowForcingMasks && force_zero_masks_i) ? '0 : rot;
endmodule

// File: tb/tb_aes_prng_masking_mc.sv
// Directed/random bench for aes_prng_masking_mc with a behavioural PRNG model.
module tb_aes_prng_masking_mc;
  localparam logic [95:0] SEED = 96'h0123_4567_89ab_cdef_f00d_cafe;

  logic        clk_i = 1'b0, rst_ni = 1'b0;
  logic        force0 = 1'b0, upd = 1'b0, req = 1'b0, eack = 1'b0;
  logic [15:0] intv = '0;
  logic [31:0] ew = '0;
  logic [95:0] data;
  logic        ack, busy, ereq;
  // second instance: reseeding skipped, mask forcing allowed
  logic        s_force = 1'b0, s_req = 1'b0, s_upd = 1'b0, s_eack = 1'b0;
  logic [15:0] s_intv = '0;
  logic [31:0] s_ew = '0;
  logic [95:0] s_data;
  logic        s_ack, s_busy, s_ereq;

  always #5 clk_i = ~clk_i;

  aes_prng_masking_mc #(.Width(96), .ChunkSize(32), .EntropyWidth(32), .CntW(16),
    .RndCnstLfsrSeed(SEED)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .force_zero_masks_i(force0), .data_update_i(upd),
    .data_o(data), .reseed_req_i(req), .reseed_ack_o(ack), .reseed_interval_i(intv),
    .reseed_busy_o(busy), .entropy_req_o(ereq), .entropy_ack_i(eack), .entropy_i(ew));

  aes_prng_masking_mc #(.Width(96), .ChunkSize(32), .EntropyWidth(32), .CntW(16),
    .SecAllowForcingMasks(1'b1), .SecSkipPRNGReseeding(1'b1), .RndCnstLfsrSeed(SEED)) u_skip (
    .clk_i(clk_i), .rst_ni(rst_ni), .force_zero_masks_i(s_force), .data_update_i(s_upd),
    .data_o(s_data), .reseed_req_i(s_req), .reseed_ack_o(s_ack), .reseed_interval_i(s_intv),
    .reseed_busy_o(s_busy), .entropy_req_o(s_ereq), .entropy_ack_i(s_eack), .entropy_i(s_ew));

  // ---------------- reference model ----------------
  int          SB [16] = '{'hB, 'hF, 3, 2, 'hA, 'hC, 9, 1, 6, 7, 8, 0, 'hE, 5, 'hD, 4};
  logic [31:0] ms [3];
  int          mph;
  logic [95:0] m_seed, rst_seed;
  int          n_pass = 0, n_tot = 0;

  function automatic logic [31:0] msub(input logic [31:0] s);
    logic [31:0] p, r;
    for (int k = 0; k < 32; k++) p[k] = s[(7*k + 3) % 32];
    for (int n = 0; n < 8; n++) r[4*n +: 4] = 4'(SB[p[4*n +: 4]]);
    return r;
  endfunction

  function automatic logic [95:0] mdata();
    logic [95:0] d;
    for (int i = 0; i < 3; i++) d[32*i +: 32] = msub(ms[(i + mph) % 3]);
    return d;
  endfunction

  task automatic m_reset();
    for (int c = 0; c < 3; c++) ms[c] = rst_seed[32*c +: 32];
    mph = 0;
  endtask

  // one clock: drive inputs, let the model follow the sampled edge, end on negedge
  task automatic cyc(input bit u, input bit a, input logic [31:0] w, input bit ap);
    upd = u; eack = a; ew = w;
    @(posedge clk_i);
    if (!rst_ni) m_reset();
    else begin
      if (ap) for (int c = 0; c < 3; c++) ms[c] = m_seed[32*c +: 32];
      else if (u) for (int c = 0; c < 3; c++) ms[c] = (ms[c] >> 1) ^ (ms[c][0] ? 32'h8000_0057 : 32'h0);
      if (u) mph = (mph + 1) % 3;
    end
    @(negedge clk_i);
    upd = 1'b0; eack = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    logic [31:0] w [3];
    bit seen;
    rst_seed = SEED;
    m_reset();
    // reset
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    rst_ni = 1'b1;
    chk("rst_data", data, mdata());
    chk("rst_hs", {ereq, ack, busy}, 3'b000);
    chk("skip_rst_data", s_data, mdata());
    chk("skip_rst_hs", {s_ereq, s_ack, s_busy}, 3'b000);
    // plain updates, phase walks 1,2,0,1
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0, 0);
      chk("upd_data", data, mdata());
      chk("upd_hs", {ereq, ack, busy}, 3'b000);
    end
    force0 = 1'b1; #1;
    chk("force_ignored", data, mdata());
    force0 = 1'b0;
    // external reseed, update in the APPLY cycle
    req = 1'b1; cyc(0, 0, 0, 0);
    chk("ext_ereq", ereq, 1'b1);
    chk("ext_busy", busy, 1'b1);
    cyc(0, 1, 32'h1111_1111, 0); cyc(0, 1, 32'h2222_2222, 0);
    chk("ext_ereq_mid", ereq, 1'b1);
    cyc(0, 1, 32'h3333_3333, 0);
    chk("ext_ereq_drop", ereq, 1'b0);
    chk("ext_ack", ack, 1'b1);
    chk("ext_old_data", data, mdata());
    req = 1'b0; m_seed = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    cyc(1, 0, 0, 1);
    chk("ext_ack_pulse", {ack, busy}, 2'b00);
    chk("ext_new_data", data, mdata());
    // auto reseed after 4 updates
    intv = 16'd4;
    for (int i = 0; i < 4; i++) begin cyc(1, 0, 0, 0); chk("auto_pre", ereq, 1'b0); end
    cyc(0, 0, 0, 0);
    chk("auto_ereq", ereq, 1'b1);
    for (int i = 0; i < 3; i++) begin w[i] = $urandom; cyc(0, 1, w[i], 0); end
    chk("auto_no_ack", {ack, busy}, 2'b01);
    m_seed = {w[2], w[1], w[0]};
    cyc(0, 0, 0, 1);
    chk("auto_data", data, mdata());
    // counter cleared: 3 updates quiet, 4th (with stray ack) triggers
    for (int i = 0; i < 3; i++) begin cyc(1, 0, 0, 0); chk("cnt_cleared", ereq, 1'b0); end
    cyc(1, 1, 32'hdead_beef, 0);
    chk("stray_idle", ereq, 1'b0);
    cyc(0, 0, 0, 0);
    chk("auto2_ereq", ereq, 1'b1);
    // gapped acks, update during COLLECT, late external request
    for (int i = 0; i < 3; i++) w[i] = $urandom;
    cyc(0, 1, w[0], 0); cyc(0, 0, 0, 0);
    req = 1'b1; cyc(1, 0, 0, 0);
    chk("collect_upd_data", data, mdata());
    cyc(0, 1, w[1], 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    chk("gap_ereq", ereq, 1'b1);
    cyc(0, 1, w[2], 0);
    chk("late_ext_ack", ack, 1'b1);
    req = 1'b0; intv = '0; m_seed = {w[2], w[1], w[0]};
    cyc(0, 0, 0, 1);
    chk("gap_data", data, mdata());
    // reset mid-COLLECT
    req = 1'b1; cyc(0, 0, 0, 0);
    cyc(0, 1, $urandom, 0); cyc(0, 1, $urandom, 0);
    rst_ni = 1'b0; req = 1'b0; cyc(0, 0, 0, 0);
    chk("midrst_hs", {ereq, ack, busy}, 3'b000);
    chk("midrst_data", data, mdata());
    rst_ni = 1'b1; req = 1'b1; cyc(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) w[i] = $urandom;
    cyc(0, 1, w[0], 0); cyc(0, 1, w[1], 0);
    chk("fresh_words", ereq, 1'b1);
    cyc(0, 1, w[2], 0);
    chk("fresh_ack", ack, 1'b1);
    req = 1'b0; m_seed = {w[2], w[1], w[0]};
    cyc(0, 0, 0, 1);
    chk("fresh_data", data, mdata());
    // interval 0: no auto-reseed, counter saturates
    seen = 1'b0;
    for (int i = 0; i < 70000; i++) begin cyc(1, 0, 0, 0); if (ereq) seen = 1'b1; end
    chk("no_auto", seen, 1'b0);
    chk("long_data", data, mdata());
    intv = 16'hffff; cyc(0, 0, 0, 0);
    chk("sat_ereq", ereq, 1'b1);
    for (int i = 0; i < 3; i++) begin w[i] = $urandom; cyc(0, 1, w[i], 0); end
    chk("sat_no_ack", ack, 1'b0);
    intv = '0; m_seed = {w[2], w[1], w[0]};
    cyc(0, 0, 0, 1);
    chk("sat_data", data, mdata());
    // reseeding skipped: combinational ack, no EDN traffic, forced masks
    s_req = 1'b1; #1;
    chk("skip_ack", s_ack, 1'b1);
    chk("skip_quiet", {s_ereq, s_busy}, 2'b00);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    chk("skip_hold", {s_ereq, s_ack, s_busy}, 3'b010);
    s_req = 1'b0; #1;
    chk("skip_ack_low", s_ack, 1'b0);
    s_force = 1'b1; #1;
    chk("skip_force", s_data, 96'h0);
    s_force = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/aes_prng_masking_mc.md
# aes_prng_masking_mc

Parametrised masking PRNG for the AES cipher core, and successor to the current two-phase masking PRNG. It keeps the per-chunk LFSR plus PRINCE S-box structure and adds three things: an internal entropy collector FSM, an auto-reseed counter that triggers reseeding after a programmable number of updates, and an N-way chunk rotation in place of the two-way swap. It sits between the cipher core (PRD consumer) and the EDN entropy interface.

## Interface
- Width, 160, output width; must be divisible by ChunkSize, 8 and EntropyWidth.
- ChunkSize, 32, LFSR width; NumChunks = Width/ChunkSize, must be ≥ 2.
- EntropyWidth, 32, entropy bus width; NumWords = Width/EntropyWidth.
- CntW, 16, width of the update counter and the interval input.
- SecAllowForcingMasks, 0, enables the force_zero_masks_i input.
- SecSkipPRNGReseeding, 0, disables all reseeding (SCA builds).
- RndCnstLfsrSeed, default masking seed, reset seed of all chunks.
- RndCnstChunkLfsrPerm, default chunk permutation, LFSR state permutation.
- clk_i  in  1  clock; single clock domain.
- rst_ni  in  1  reset; synchronous, active-low.
- force_zero_masks_i  in  1  forces data_o to 0 when SecAllowForcingMasks is set.
- data_update_i  in  1  consumer took data_o; step the LFSRs and advance the phase.
- data_o  out  Width  masking PRD.
- reseed_req_i  in  1  external reseed request (level); held until ack.
- reseed_ack_o  out  1  one-cycle pulse completing an external request.
- reseed_interval_i  in  CntW  update count that triggers auto-reseed; 0 disables auto-reseed.
- reseed_busy_o  out  1  high while the FSM is not IDLE.
- entropy_req_o  out  1  EDN request.
- entropy_ack_i  in  1  EDN word valid.
- entropy_i  in  EntropyWidth  EDN word.

## Operation
- NumChunks prim_lfsr instances of type GAL_XOR with StatePermEn=1. Chunk c takes seed bits [c*ChunkSize +: ChunkSize]. seed_en has priority over lfsr_en. entropy_i input is tied to 0.
- sub = per-byte PRINCE sbox4_8bit of the concatenated LFSR state.
- Phase register phase_q is in 0..NumChunks-1 and increments on data_update_i, wrapping NumChunks-1 -> 0. It is not cleared by reseeding.
- Output chunk i = sub[(i+phase_q) mod NumChunks]. data_o = 0 when SecAllowForcingMasks && force_zero_masks_i.
- Update counter upd_cnt (CntW bits):
  - increments on data_update_i and saturates at all-ones;
  - clears in APPLY.
- auto_due = (reseed_interval_i != 0) && (upd_cnt >= reseed_interval_i), using the live interval value.
- FSM states and transitions:
  - IDLE -> COLLECT when reseed_req_i || auto_due. Latch ext_pend = reseed_req_i. A request arriving later during COLLECT also sets ext_pend.
  - COLLECT: entropy_req_o=1. On entropy_ack_i, write entropy_i into seed word wcnt (word 0 = bits [EntropyWidth-1:0]) and increment wcnt. On the ack with wcnt==NumWords-1, go to APPLY.
  - APPLY (1 cycle): seed_en=1 with the assembled seed; upd_cnt := 0; wcnt := 0; reseed_ack_o = ext_pend; ext_pend cleared; go to IDLE.
- entropy_ack_i while entropy_req_o=0 is ignored.
- Only the data_update_i in the APPLY cycle is overridden by seeding; phase_q and upd_cnt still count it before the clear. Updates during COLLECT step the old sequence.
- SecSkipPRNGReseeding=1:
  - FSM stays in IDLE; entropy_req_o=0; auto-reseed disabled;
  - reseed_ack_o = reseed_req_i combinationally; reseed_busy_o=0.

## Timing
- Reset values: FSM IDLE, phase_q=0, upd_cnt=0, wcnt=0, ext_pend=0, LFSRs=RndCnstLfsrSeed. All handshake outputs (entropy_req_o, reseed_ack_o, reseed_busy_o) are 0. data_o = sub of the reset state, unrotated.
- entropy_req_o and reseed_busy_o rise the cycle after the trigger is sampled. Both are registered from state.
- After the last ack: APPLY in the next cycle (reseed_ack_o high), and the new data_o appears the cycle after APPLY.
- Minimum reseed latency is NumWords+2 cycles from trigger.
- Reset asserted mid-COLLECT discards the partial seed. The next reseed needs NumWords fresh words.

## Test plan
- Width=96, ChunkSize=32, EntropyWidth=32. Reset, then 4 updates -> phase 0,1,2,0. data_o matches the golden model each cycle. All handshake outputs stay 0.
- reseed_req_i=1; acks with words 0x11111111, 0x22222222, 0x33333333 -> entropy_req_o drops after the 3rd ack. reseed_ack_o pulses in the next cycle. The following data_o matches the model seeded with {0x33333333,0x22222222,0x11111111}.
- reseed_interval_i=4, 4 updates -> entropy_req_o rises the next cycle. After 3 words, reseed_ack_o stays 0 and upd_cnt reads 0. With interval=0, 70000 updates give no request.
- Acks with 2-cycle gaps, plus an ack while the request is low -> the stray ack is ignored and the seed is assembled from exactly 3 accepted words.
- rst_ni low after 2 words -> all handshake outputs 0 next cycle. A new request needs 3 words.
- SecSkipPRNGReseeding=1: reseed_req_i=1 -> reseed_ack_o=1 in the same cycle, entropy_req_o=0. With SecAllowForcingMasks=1 and force_zero_masks_i=1 -> data_o=0.
